// File: rtl/tdm_demux16_pkg.sv
// Shared types and defaults for the 16-channel TDM receive path.
package tdm_pkg;
  localparam int N_CH_DEFAULT = 16;

  typedef enum logic {IDLE, FILL} tdm_state_t;

  typedef logic [3:0] ch_sel_t;
endpackage

// File: rtl/tdm_demux16_if.sv
// Serial-in / parallel-out bundle between the TDM source and the demultiplexer.
interface tdm_demux16_if
  import tdm_pkg::*;
#(
  parameter int N_CH = N_CH_DEFAULT
);
  localparam int SEL_W = $clog2(N_CH);

  // din_valid qualifies din and sync in the same cycle; there is no ready,
  // the receiver consumes every valid beat on the edge that samples it.
  logic              din;
  logic              din_valid;
  logic              sync;
  logic              mode;
  logic [SEL_W-1:0]  sel_ext;
  logic [N_CH-1:0]   y;
  logic [SEL_W-1:0]  ch_idx;
  logic              busy;
  logic              frame_done;
  logic              err_sync;
  tdm_state_t        dbg_state;

  modport master (
    output din, din_valid, sync, mode, sel_ext,
    input  y, ch_idx, busy, frame_done, err_sync, dbg_state
  );

  modport slave (
    input  din, din_valid, sync, mode, sel_ext,
    output y, ch_idx, busy, frame_done, err_sync, dbg_state
  );
endinterface

// File: rtl/tdm_demux16_chan_counter.sv
// Channel index counter: clear beats load-to-1, which beats increment.
module tdm_chan_counter #(
  parameter  int N_CH  = 16,
  localparam int SEL_W = $clog2(N_CH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load1_i,
  input  logic             inc_i,
  input  logic             clear_i,
  output logic [SEL_W-1:0] cnt_o,
  output logic             wrap_o
);
  logic [SEL_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clear_i) begin
      cnt_d = '0;
    end else if (load1_i) begin
      cnt_d = SEL_W'(1);
    end else if (inc_i) begin
      cnt_d = cnt_q + SEL_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o  = cnt_q;
  assign wrap_o = (cnt_q == SEL_W'(N_CH - 1));
endmodule

// File: rtl/tdm_demux16.sv
// 1-to-16 TDM demultiplexer: sync-started frames into a shadow register,
// committed to y in one shot, plus a direct external-select write path.
module tdm_demux16
  import tdm_pkg::*;
#(
  parameter int N_CH = N_CH_DEFAULT
) (
  input logic          clk,
  input logic          rst_n,
  tdm_demux16_if.slave bus
);
  localparam int SEL_W = $clog2(N_CH);

  tdm_state_t       state_q, state_d;
  logic [N_CH-1:0]  shadow_q, shadow_d;
  logic [N_CH-1:0]  y_q, y_d;
  logic             done_q, done_d;
  logic             err_q, err_d;
  logic             cnt_load1, cnt_inc, cnt_clear, cnt_wrap;
  logic [SEL_W-1:0] cnt;

  tdm_chan_counter #(.N_CH(N_CH)) u_cnt (
    .clk     (clk),
    .rst_n   (rst_n),
    .load1_i (cnt_load1),
    .inc_i   (cnt_inc),
    .clear_i (cnt_clear),
    .cnt_o   (cnt),
    .wrap_o  (cnt_wrap)
  );

  always_comb begin
    state_d   = state_q;
    shadow_d  = shadow_q;
    y_d       = y_q;
    done_d    = 1'b0;
    err_d     = 1'b0;
    cnt_load1 = 1'b0;
    cnt_inc   = 1'b0;
    cnt_clear = 1'b0;
    if (bus.mode) begin
      // External select bypasses the shadow and silently abandons any frame.
      state_d   = IDLE;
      cnt_clear = 1'b1;
      if (bus.din_valid) begin
        y_d[bus.sel_ext] = bus.din;
      end
    end else if (bus.din_valid) begin
      case (state_q)
        IDLE: begin
          if (bus.sync) begin
            shadow_d[0] = bus.din;
            cnt_load1   = 1'b1;
            state_d     = FILL;
          end
        end
        FILL: begin
          if (bus.sync) begin
            err_d       = 1'b1;
            shadow_d    = '0;
            shadow_d[0] = bus.din;
            cnt_load1   = 1'b1;
          end else if (cnt_wrap) begin
            y_d       = {bus.din, shadow_q[N_CH-2:0]};
            done_d    = 1'b1;
            cnt_clear = 1'b1;
            state_d   = IDLE;
          end else begin
            shadow_d[cnt] = bus.din;
            cnt_inc       = 1'b1;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      shadow_q <= '0;
      y_q      <= '0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      shadow_q <= shadow_d;
      y_q      <= y_d;
      done_q   <= done_d;
      err_q    <= err_d;
    end
  end

  assign bus.y          = y_q;
  assign bus.ch_idx     = cnt;
  assign bus.busy       = (state_q == FILL);
  assign bus.frame_done = done_q;
  assign bus.err_sync   = err_q;
  assign bus.dbg_state  = state_q;
endmodule

// File: tb/tb_tdm_demux16.sv
// Bench for tdm_demux16: directed frames from the test plan, then random traffic
// checked cycle by cycle against a bit-queue model of the frame rules.
module tb_tdm_demux16;
  import tdm_pkg::*;

  localparam int N_CH = 16;
  localparam int W    = N_CH;

  // clock / reset
  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  tdm_demux16_if #(.N_CH(N_CH)) bus ();
  tdm_demux16 #(.N_CH(N_CH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // behavioural model: a frame is the list of bits since the accepted sync
  logic [W-1:0] m_y;
  bit           m_bits[$];
  bit           m_in, m_done, m_err;
  logic [W-1:0] exp_q[$];

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_y = '0;
      m_bits.delete();
      m_in = 0;
      m_done = 0;
      m_err = 0;
      exp_q.delete();
    end else begin
      m_done = 0;
      m_err  = 0;
      if (bus.mode) begin
        if (bus.din_valid) m_y[bus.sel_ext] = bus.din;
        m_bits.delete();
        m_in = 0;
      end else if (bus.din_valid) begin
        if (bus.sync) begin
          if (m_in) m_err = 1;
          m_bits.delete();
          m_bits.push_back(bus.din);
          m_in = 1;
        end else if (m_in) begin
          m_bits.push_back(bus.din);
          if (m_bits.size() == W) begin
            for (int i = 0; i < W; i++) m_y[i] = m_bits[i];
            m_done = 1;
            exp_q.push_back(m_y);
            m_bits.delete();
            m_in = 0;
          end
        end
      end
    end
  end

  // compare process + scoreboard
  int cyc = 0;
  int done_cnt = 0;
  int err_cnt = 0;
  int done_cyc[$];

  always @(negedge clk) begin
    cyc++;
    check("y", 32'(bus.y), 32'(m_y));
    check("ch_idx", 32'(bus.ch_idx), 32'(m_bits.size()));
    check("busy", 32'(bus.busy), 32'(m_in));
    check("frame_done", 32'(bus.frame_done), 32'(m_done));
    check("err_sync", 32'(bus.err_sync), 32'(m_err));
    if (bus.frame_done) begin
      done_cnt++;
      done_cyc.push_back(cyc);
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL sb_word: frame_done with y=0x%0h but no expected word queued", bus.y);
      end else begin
        check("sb_word", 32'(bus.y), 32'(exp_q.pop_front()));
      end
    end
    if (bus.err_sync) err_cnt++;
  end

  // driver tasks
  task automatic drive(bit v, bit d, bit s, bit m, logic [3:0] sel);
    @(posedge clk);
    #1;
    bus.din_valid = v;
    bus.din       = d;
    bus.sync      = s;
    bus.mode      = m;
    bus.sel_ext   = sel;
  endtask

  task automatic beat(bit d, bit s);
    drive(1'b1, d, s, 1'b0, 4'd0);
  endtask

  task automatic idle();
    drive(1'b0, 1'b0, 1'b0, 1'b0, 4'd0);
  endtask

  task automatic send_frame(logic [W-1:0] w);
    for (int i = 0; i < W; i++) beat(w[i], i == 0);
  endtask

  task automatic do_reset();
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    bus.din_valid = 0;
    bus.din = 0;
    bus.sync = 0;
    bus.mode = 0;
    bus.sel_ext = '0;
    repeat (2) @(posedge clk);
    #2;
    rst_n = 1'b1;
    done_cnt = 0;
    err_cnt = 0;
    done_cyc.delete();
  endtask

  initial begin
    bus.din_valid = 0;
    bus.din = 0;
    bus.sync = 0;
    bus.mode = 0;
    bus.sel_ext = '0;
    do_reset();
    idle();
    check("rst_y", 32'(bus.y), 32'h0);
    check("rst_ch_idx", 32'(bus.ch_idx), 32'h0);
    check("rst_busy", 32'(bus.busy), 32'h0);

    // contiguous frame
    send_frame(16'h14A0);
    idle();
    check("f14a0_y", 32'(bus.y), 32'h14A0);
    check("f14a0_done", 32'(bus.frame_done), 32'h1);
    idle();
    check("f14a0_done_cnt", 32'(done_cnt), 32'd1);
    check("f14a0_busy", 32'(bus.busy), 32'h0);

    // early sync
    do_reset();
    for (int i = 0; i < 9; i++) beat(1'b1, i == 0);
    idle();
    check("early_y_before", 32'(bus.y), 32'h0);
    check("early_busy", 32'(bus.busy), 32'h1);
    send_frame(16'h00FF);
    idle();
    idle();
    check("early_y", 32'(bus.y), 32'h00FF);
    check("early_err_cnt", 32'(err_cnt), 32'd1);
    check("early_done_cnt", 32'(done_cnt), 32'd1);

    // gapped frame
    do_reset();
    for (int i = 0; i < W; i++) begin
      beat(16'hA5A5 >> i, i == 0);
      if (i < W - 1) idle();
      if (i == 4) check("gap_ch_idx", 32'(bus.ch_idx), 32'd5);
    end
    idle();
    check("gap_y", 32'(bus.y), 32'hA5A5);

    // external select
    do_reset();
    drive(1'b1, 1'b1, 1'b1, 1'b1, 4'd3);
    drive(1'b1, 1'b1, 1'b0, 1'b1, 4'd15);
    drive(1'b0, 1'b0, 1'b0, 1'b1, 4'd0);
    check("ext_y", 32'(bus.y), 32'h8008);
    idle();
    check("ext_done_cnt", 32'(done_cnt), 32'd0);
    check("ext_err_cnt", 32'(err_cnt), 32'd0);

    // asynchronous reset mid-frame
    do_reset();
    send_frame(16'h1234);
    for (int i = 0; i < 7; i++) beat(1'b1, i == 0);
    #3;
    rst_n = 1'b0;
    #1;
    check("arst_y", 32'(bus.y), 32'h0);
    check("arst_ch_idx", 32'(bus.ch_idx), 32'h0);
    check("arst_busy", 32'(bus.busy), 32'h0);
    #10;
    rst_n = 1'b1;
    send_frame(16'hFFFF);
    idle();
    check("arst_ffff_y", 32'(bus.y), 32'hFFFF);

    // back-to-back frames
    do_reset();
    send_frame(16'h1234);
    send_frame(16'hFEDC);
    idle();
    idle();
    check("b2b_done_cnt", 32'(done_cnt), 32'd2);
    if (done_cyc.size() == 2) check("b2b_spacing", 32'(done_cyc[1] - done_cyc[0]), 32'd16);
    else begin
      errors++;
      $display("FAIL b2b_spacing: saw %0d frame_done pulses, need 2", done_cyc.size());
    end
    check("b2b_y", 32'(bus.y), 32'hFEDC);

    // randomized traffic
    do_reset();
    begin
      bit m = 0;
      for (int n = 0; n < 4000; n++) begin
        if ($urandom_range(0, 59) == 0) m = ~m;
        drive($urandom_range(0, 3) != 0, 1'($urandom_range(0, 1)),
              $urandom_range(0, 23) == 0, m, 4'($urandom_range(0, 15)));
      end
    end
    idle();
    idle();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
